data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/load_store_align.sv | 58 +++++
 rtl/data_mem_unit.sv | 171 +++++++++++++++++
 tb/tb_data_mem_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory unit: FSM state, RISC-V
// load/store width codes and the wait-state counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Wide enough for the legal wait-state range 0..15.
  localparam int WAIT_CNT_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane logic: byte enables, store-data replication, load extract/extend
// and alignment check. Sub-word accesses exist only with DMEM_BYTE_ACCESS_EN.
module load_store_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rword,
  output logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   wdata_al,
  output logic [DATA_WIDTH-1:0]   rdata_ext,
  output logic                    misaligned
);

  localparam int NB = DATA_WIDTH / 8;

`ifdef DMEM_BYTE_ACCESS_EN
  localparam logic [NB-1:0] ONE_LANE = {{(NB-1){1'b0}}, 1'b1};
  localparam logic [NB-1:0] TWO_LANE = {{(NB-2){1'b0}}, 2'b11};

  logic [DATA_WIDTH-1:0] rshift;
  assign rshift = rword >> {addr_lo, 3'b000};
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
`endif

  always_comb begin
    // Full-word access is the default; unsupported codes fall through to it.
    byte_en    = '1;
    wdata_al   = wdata;
    rdata_ext  = rword;
    misaligned = (addr_lo != 2'b00);
`ifdef DMEM_BYTE_ACCESS_EN
    case (funct3)
      F3_B, F3_BU: begin
        misaligned = 1'b0;
        byte_en    = ONE_LANE << addr_lo;
        wdata_al   = {NB{wdata[7:0]}};
        rdata_ext  = (funct3 == F3_B) ? {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]}
                                      : {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
      end
      F3_H, F3_HU: begin
        misaligned = addr_lo[0];
        byte_en    = TWO_LANE << addr_lo;
        wdata_al   = {(NB/2){wdata[15:0]}};
        rdata_ext  = (funct3 == F3_H) ? {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]}
                                      : {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
      end
      default: ;
    endcase
`endif
  end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory with fixed wait states (IDLE -> WAIT -> RESP).
// Define DMEM_BYTE_ACCESS_EN to enable byte/halfword loads and stores.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReqM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallMemM,
  output logic                  MisalignM,
  output dmem_state_e           dbg_state
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  // Handshake: a request is offered by MemReqM in IDLE. It is taken in that
  // same cycle (StallMemM rises combinationally) unless misaligned, and the
  // pipeline stays frozen while StallMemM is high; RESP is the release cycle
  // in which ReadDataM carries the load result.
  dmem_state_e state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

  logic                  in_idle;
  logic                  sel_we;
  logic [2:0]            sel_f3;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] rword;
  logic [NB-1:0]         byte_en;
  logic [DATA_WIDTH-1:0] wdata_al;
  logic [DATA_WIDTH-1:0] rdata_ext;
  logic                  misaligned;
  logic                  enter_resp;
  logic                  mem_we;

  // Live inputs drive the datapath only in IDLE; afterwards the captured copy
  // is used so input changes during WAIT/RESP cannot affect the access.
  assign in_idle   = (state_q == ST_IDLE);
  assign sel_we    = in_idle ? MemWriteM  : we_q;
  assign sel_f3    = in_idle ? Funct3M    : f3_q;
  assign sel_addr  = in_idle ? ALUResultM : addr_q;
  assign sel_wdata = in_idle ? WriteDataM : wdata_q;
  assign mem_idx   = sel_addr[IDX_W+1:2];
  assign rword     = ram[mem_idx];

  // Address bits above the RAM index wrap around.
  logic unused_addr_bits;
  assign unused_addr_bits = ^sel_addr[DATA_WIDTH-1:IDX_W+2];

  load_store_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .funct3     (sel_f3),
    .addr_lo    (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_al   (wdata_al),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    StallMemM  = 1'b0;
    MisalignM  = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MemReqM) begin
          if (misaligned) begin
            MisalignM = 1'b1;
          end else begin
            StallMemM = 1'b1;
            we_d      = MemWriteM;
            f3_d      = Funct3M;
            addr_d    = ALUResultM;
            wdata_d   = WriteDataM;
            if (WAIT_CYCLES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d    = ST_RESP;
              enter_resp = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        StallMemM = 1'b1;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp && !sel_we) rdata_d = rdata_ext;
    mem_we = enter_resp && sel_we;

    // Reset aborts any in-flight access, including its pending write.
    if (reset) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      rdata_d   = '0;
      StallMemM = 1'b0;
      MisalignM = 1'b0;
      mem_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    rdata_q <= rdata_d;
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) ram[mem_idx][8*i +: 8] <= wdata_al[8*i +: 8];
      end
    end
  end

  assign ReadDataM = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: one instance with 2 wait states, one with none,
// checked against an address-level memory model.
module tb_data_mem_unit;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'b010;
  logic [31:0] addr = '0, wd = '0;
  logic [31:0] rd0, rd1;
  logic        stall0, stall1, mis0, mis1;
  dmem_state_e st0, st1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_m [int];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  data_mem_unit #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .MemReqM(req0), .MemWriteM(we), .Funct3M(f3),
    .ALUResultM(addr), .WriteDataM(wd), .ReadDataM(rd0), .StallMemM(stall0),
    .MisalignM(mis0), .dbg_state(st0)
  );

  data_mem_unit #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .MemReqM(req1), .MemWriteM(we), .Funct3M(f3),
    .ALUResultM(addr), .WriteDataM(wd), .ReadDataM(rd1), .StallMemM(stall1),
    .MisalignM(mis1), .dbg_state(st1)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int key(input bit which, input logic [31:0] a);
    return int'(which) * 4096 + int'((a / 4) % 1024);
  endfunction

  function automatic bit model_mis(input logic [2:0] fc, input logic [31:0] a);
`ifdef DMEM_BYTE_ACCESS_EN
    if (fc == 3'd0 || fc == 3'd4) return 1'b0;
    if (fc == 3'd1 || fc == 3'd5) return (a % 2) != 0;
`endif
    return (a % 4) != 0 && fc !== 3'bzzz;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] fc,
                                             input logic [31:0] a);
    logic [31:0] b, h;
    b = (word >> (8 * (a % 4))) & 32'hFF;
    h = (word >> (8 * (a % 4))) & 32'hFFFF;
`ifdef DMEM_BYTE_ACCESS_EN
    if (fc == 3'd0) return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
    if (fc == 3'd4) return b;
    if (fc == 3'd1) return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
    if (fc == 3'd5) return h;
`endif
    return (fc === 3'bzzz) ? b ^ h : word;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] fc,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    sh = 8 * int'(a % 4);
    mask = 32'hFFFFFFFF;
`ifdef DMEM_BYTE_ACCESS_EN
    if (fc == 3'd0 || fc == 3'd4) mask = 32'hFF << sh;
    else if (fc == 3'd1 || fc == 3'd5) mask = 32'hFFFF << sh;
`endif
    return (word & ~mask) | ((d << sh) & mask);
  endfunction

  // ---------------- driver ----------------
  task automatic do_access(input bit which, input bit st, input logic [2:0] fc,
                           input logic [31:0] a, input logic [31:0] d, input string tag);
    bit          mis;
    int          k, nstall, wc;
    logic [31:0] exp_rd, cur;
    wc     = which ? 0 : 2;
    mis    = model_mis(fc, a);
    k      = key(which, a);
    exp_rd = last_rd[which];
    cur    = mem_m.exists(k) ? mem_m[k] : 32'h0;
    if (!mis) begin
      if (st) mem_m[k] = model_store(cur, fc, a, d);
      else    exp_rd = model_load(cur, fc, a);
    end

    @(posedge clk); #1;
    if (which) req1 = 1'b1; else req0 = 1'b1;
    we = st; f3 = fc; addr = a; wd = d;
    @(negedge clk);
    if (mis) begin
      check({tag, "_mis"},   32'(which ? mis1 : mis0), 32'd1);
      check({tag, "_nostl"}, 32'(which ? stall1 : stall0), 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check({tag, "_mis_end"}, 32'(which ? mis1 : mis0), 32'd0);
      check({tag, "_idle"},    32'(which ? st1 : st0), 32'(ST_IDLE));
      check({tag, "_rdkeep"},  which ? rd1 : rd0, exp_rd);
    end else begin
      nstall = 0;
      while ((which ? stall1 : stall0) && nstall < 20) begin
        nstall++;
        @(posedge clk); #1;
        // Scribble on the request inputs; the access must ignore them.
        if (which) req1 = 1'($urandom); else req0 = 1'($urandom);
        we = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
        @(negedge clk);
      end
      check({tag, "_stalls"}, 32'(nstall), 32'(wc + 1));
      check({tag, "_resp"},   32'(which ? st1 : st0), 32'(ST_RESP));
      check({tag, "_rdata"},  which ? rd1 : rd0, exp_rd);
      req0 = 1'b0; req1 = 1'b0;
      last_rd[which] = exp_rd;
    end
  endtask

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rd0",    rd0, 32'h0);
    check("rst_stall0", 32'(stall0), 32'd0);
    check("rst_mis0",   32'(mis0), 32'd0);
    check("rst_state0", 32'(st0), 32'(ST_IDLE));
    check("rst_rd1",    rd1, 32'h0);
    check("rst_state1", 32'(st1), 32'(ST_IDLE));

    // Word store then load with wait states
    do_access(0, 1, F3_W, 32'h10, 32'hDEADBEEF, "sw10");
    do_access(0, 0, F3_W, 32'h10, 32'h0, "lw10");
    check("lw10_const", rd0, 32'hDEADBEEF);

    // Sub-word loads (misaligned when byte access is disabled)
    do_access(0, 0, F3_B,  32'h13, 32'h0, "lb13");
    do_access(0, 0, F3_BU, 32'h13, 32'h0, "lbu13");
    do_access(0, 0, F3_H,  32'h12, 32'h0, "lh12");
`ifdef DMEM_BYTE_ACCESS_EN
    check("lh12_const", rd0, 32'hFFFFDEAD);
`endif

    // Byte store, then verify other lanes untouched
    do_access(0, 1, F3_B, 32'h11, 32'h00000055, "sb11");
    do_access(0, 0, F3_W, 32'h10, 32'h0, "lw10_b");
`ifdef DMEM_BYTE_ACCESS_EN
    check("lw10_b_const", rd0, 32'hDEAD55EF);
`else
    check("lw10_b_const", rd0, 32'hDEADBEEF);
`endif

    // Misaligned requests
    do_access(0, 0, F3_W, 32'h12, 32'h0, "lw12_mis");
    do_access(0, 1, F3_H, 32'h11, 32'hFFFF, "sh11_mis");
    do_access(0, 0, F3_W, 32'h10, 32'h0, "lw10_c");
    do_access(0, 0, 3'b011, 32'h10, 32'h0, "lw10_f3unsup");

    // Reset during the second WAIT cycle aborts the store
    do_access(0, 1, F3_W, 32'h20, 32'hA5A50F0F, "sw20");
    @(posedge clk); #1;
    req0 = 1'b1; we = 1'b1; f3 = F3_W; addr = 32'h20; wd = 32'h12345678;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    check("abort_in_wait", 32'(st0), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    check("abort_stall", 32'(stall0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(st0), 32'(ST_IDLE));
    check("abort_rd0",  rd0, 32'h0);
    check("abort_rd1",  rd1, 32'h0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    do_access(0, 0, F3_W, 32'h20, 32'h0, "lw20_after_abort");
    check("lw20_const", rd0, 32'hA5A50F0F);

    // Zero wait states: back-to-back accesses and address aliasing
    do_access(1, 1, F3_W, 32'h10,   32'hCAFEF00D, "z_sw10");
    do_access(1, 0, F3_W, 32'h1010, 32'h0, "z_lw1010");
    check("alias_const", rd1, 32'hCAFEF00D);
    do_access(1, 1, F3_W, 32'h14,   32'h0BADC0DE, "z_sw14");
    do_access(1, 0, F3_W, 32'h14,   32'h0, "z_lw14");

    // Randomized traffic over a small window with aliasing upper bits
    for (int w = 0; w < 16; w++) begin
      do_access(0, 1, F3_W, 32'(4 * w), $urandom, "init0");
      do_access(1, 1, F3_W, 32'(4 * w), $urandom, "init1");
    end
    for (int n = 0; n < 80; n++) begin
      do_access(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12),
                $urandom, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
